// File: rtl/wbuff_pkg.sv
// Shared types and helpers for the weight-buffer bank filler.
//   fill_state_e : sequencing FSM states
//   NbActiveTaps : taps that can actually be loaded per bank
//   clogb2       : address width for a given word count
//   sat8         : clamp a signed value to the signed 8-bit range
package wbuff_pkg;

  localparam int unsigned NbActiveTaps = 3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFill,
    StGap,
    StRead,
    StDone
  } fill_state_e;

  // Smallest width able to address n words (at least 1).
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [31:0] x);
    if (x > 32'sd127) return 8'h7f;
    else if (x < -32'sd128) return 8'h80;
    else return x[7:0];
  endfunction

endpackage

// File: rtl/wbuff_bank_filler_if.sv
// Weight stream handshake between the weight DMA (master) and the bank filler (slave).
//   s_valid : master has a word on s_data
//   s_ready : slave accepts the word this cycle
//   s_data  : weight word
interface wbuff_bank_filler_if #(
  parameter int unsigned DataWidth = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DataWidth-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/wbuff_addr_wrap.sv
// Loadable address counter that wraps at Depth-1 -> 0 (Depth need not be a power of two).
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : load load_val_i (wins over inc_i)
//   load_val_i : value to load
//   inc_i      : advance by one, modulo Depth
//   addr_o     : current address (registered)
module wbuff_addr_wrap #(
  parameter int unsigned Depth = 72,
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] addr_o
);

  logic [Width-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = (addr_q == Width'(Depth - 1)) ? '0 : addr_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/wbuff_bank_filler.sv
// Fills one weight-buffer bank: writes a valid/ready weight stream into the bank SRAM
// (active-low strobes), then issues SRAM reads and one-hot tap-load enables so the bank's
// weight registers capture the first taps of the job.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_i             : begin a job (ignored while busy_o)
//   cfg_base_addr_i     : first SRAM address of the job
//   cfg_len_i           : words to write
//   cfg_ntaps_i         : taps to load (clamped to NbActiveTaps)
//   s_if                : weight stream (slave side)
//   w_addr_o, buffer_data_in_o, buffer_wen_o : SRAM write port, strobe active-low
//   r_addr_o, buffer_ren_o                   : SRAM read port, strobe active-low
//   weight_load_en_o    : one-hot tap capture enable
//   clear_all_wregs_o   : clears the bank weight registers
//   busy_o, done_o      : job active / one-cycle completion pulse
// Build option: define WBUFF_FILL_SAT8_EN to saturate incoming words to signed 8 bits.
module wbuff_bank_filler
  import wbuff_pkg::*;
#(
  parameter int unsigned BufferDepth     = 72,
  parameter int unsigned BufferWidth     = 16,
  parameter int unsigned BufferAddrWidth = clogb2(BufferDepth),
  parameter int unsigned NbTaps          = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [BufferAddrWidth-1:0] cfg_base_addr_i,
  input  logic [BufferAddrWidth:0]   cfg_len_i,
  input  logic [3:0]                 cfg_ntaps_i,
  wbuff_bank_filler_if.slave         s_if,
  output logic [BufferAddrWidth-1:0] w_addr_o,
  output logic [BufferWidth-1:0]     buffer_data_in_o,
  output logic                       buffer_wen_o,
  output logic [BufferAddrWidth-1:0] r_addr_o,
  output logic                       buffer_ren_o,
  output logic [NbTaps-1:0]          weight_load_en_o,
  output logic                       clear_all_wregs_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned Aw         = BufferAddrWidth;
  localparam logic [3:0]  MaxTaps    = 4'(NbActiveTaps);
  localparam logic [NbTaps-1:0] TapMask = NbTaps'((1 << NbActiveTaps) - 1);

  fill_state_e state_q, state_d;

  logic [Aw-1:0]          base_q;
  logic [Aw:0]            len_q, cnt_q, cnt_d;
  logic [3:0]             ntaps_q, tap_q, tap_d;
  logic                   beat, cfg_en;
  logic                   w_load, w_inc, r_load, r_inc;
  logic [BufferWidth-1:0] beat_data;

  logic                   wen_q, ren_q, clear_q, busy_q, done_q;
  logic [BufferWidth-1:0] wdata_q;
  logic [NbTaps-1:0]      load_en_q;

  assign s_if.s_ready = (state_q == StFill);
  assign beat         = s_if.s_valid && s_if.s_ready;
  assign cfg_en       = (state_q == StIdle) && start_i;

`ifdef WBUFF_FILL_SAT8_EN
  logic [7:0] sat_byte;
  assign sat_byte  = sat8(32'(signed'(s_if.s_data)));
  assign beat_data = {{(BufferWidth - 8){sat_byte[7]}}, sat_byte};
`else
  assign beat_data = s_if.s_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    r_load  = 1'b0;
    r_inc   = 1'b0;
    unique case (state_q)
      StIdle: if (start_i) state_d = StClear;
      StClear: begin
        cnt_d = '0;
        if (len_q != '0) begin
          state_d = StFill;
        end else if (ntaps_q != '0) begin
          state_d = StRead;
          r_load  = 1'b1;
          tap_d   = '0;
        end else begin
          state_d = StDone;
        end
      end
      StFill: begin
        if (beat) begin
          cnt_d  = cnt_q + 1'b1;
          // First beat seeds the write counter with the base; later beats advance it.
          w_load = (cnt_q == '0);
          w_inc  = (cnt_q != '0);
          if (cnt_q + 1'b1 == len_q) state_d = (ntaps_q != '0) ? StGap : StDone;
        end
      end
      // Final write strobe is on the bus this cycle; reads start next cycle.
      StGap: begin
        state_d = StRead;
        r_load  = 1'b1;
        tap_d   = '0;
      end
      StRead: begin
        if (tap_q == ntaps_q - 4'd1) begin
          state_d = StDone;
        end else begin
          r_inc = 1'b1;
          tap_d = tap_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tap_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      ntaps_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      if (cfg_en) begin
        base_q  <= cfg_base_addr_i;
        len_q   <= cfg_len_i;
        ntaps_q <= (cfg_ntaps_i > MaxTaps) ? MaxTaps : cfg_ntaps_i;
      end
    end
  end

  // Registered outputs; load enable trails its SRAM read by one cycle (read data latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b1;
      ren_q     <= 1'b1;
      wdata_q   <= '0;
      load_en_q <= '0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wen_q     <= !beat;
      ren_q     <= (state_d != StRead);
      if (beat) wdata_q <= beat_data;
      load_en_q <= (state_q == StRead) ? ((NbTaps'(1) << tap_q) & TapMask) : '0;
      clear_q   <= (state_d == StClear);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
    end
  end

  wbuff_addr_wrap #(
    .Depth (BufferDepth),
    .Width (Aw)
  ) u_waddr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_load),
    .load_val_i (base_q),
    .inc_i      (w_inc),
    .addr_o     (w_addr_o)
  );

  wbuff_addr_wrap #(
    .Depth (BufferDepth),
    .Width (Aw)
  ) u_raddr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (r_load),
    .load_val_i (base_q),
    .inc_i      (r_inc),
    .addr_o     (r_addr_o)
  );

  assign buffer_wen_o      = wen_q;
  assign buffer_ren_o      = ren_q;
  assign buffer_data_in_o  = wdata_q;
  assign weight_load_en_o  = load_en_q;
  assign clear_all_wregs_o = clear_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_wbuff_bank_filler.sv
// Directed bench for wbuff_bank_filler: runs fill jobs and compares the logged SRAM
// write/read traffic, tap-load enables and handshake timing against hand-computed values.
module tb_wbuff_bank_filler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  cfg_base;
  logic [7:0]  cfg_len;
  logic [3:0]  cfg_ntaps;
  logic [6:0]  w_addr, r_addr;
  logic [15:0] wdata;
  logic        wen, ren, clear, busy, done;
  logic [10:0] load_en;

  wbuff_bank_filler_if #(.DataWidth(16)) s_if ();

  wbuff_bank_filler dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start),
    .cfg_base_addr_i   (cfg_base),
    .cfg_len_i         (cfg_len),
    .cfg_ntaps_i       (cfg_ntaps),
    .s_if              (s_if),
    .w_addr_o          (w_addr),
    .buffer_data_in_o  (wdata),
    .buffer_wen_o      (wen),
    .r_addr_o          (r_addr),
    .buffer_ren_o      (ren),
    .weight_load_en_o  (load_en),
    .clear_all_wregs_o (clear),
    .busy_o            (busy),
    .done_o            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Traffic monitor, sampled on the falling edge.
  logic [31:0] wr_log[$], rd_log[$], ld_log[$], exp_q[$];
  int cyc, n_clear, n_done, clear_cyc, done_cyc, ld_bad, coll;
  logic [10:0] ld_or;
  bit prev_ren_low;

  task automatic clear_mon();
    wr_log.delete(); rd_log.delete(); ld_log.delete();
    n_clear = 0; n_done = 0; clear_cyc = 0; done_cyc = 0;
    ld_bad = 0; coll = 0; ld_or = '0; prev_ren_low = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (!wen) wr_log.push_back((32'(w_addr) << 16) | 32'(wdata));
      if (!ren) rd_log.push_back(32'(r_addr));
      if (load_en != '0) begin
        ld_log.push_back(32'(load_en));
        ld_or = ld_or | load_en;
        if (!prev_ren_low) ld_bad++;
      end
      prev_ren_low = !ren;
      if (!wen && !ren) coll++;
      if (clear) begin n_clear++; clear_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  task automatic cmp_list(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check_eq({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {26'd0, wen, ren, clear, busy, done, s_if.s_ready}, 32'b110000);
    check_eq({tag, "_addr"}, {18'd0, w_addr, r_addr}, 32'd0);
    check_eq({tag, "_wdata"}, 32'(wdata), 32'd0);
    check_eq({tag, "_load_en"}, 32'(load_en), 32'd0);
  endtask

  logic [15:0] words[$];

  // Runs one job; toggle alternates s_valid, poke holds start high while busy with other cfg.
  task automatic run_job(input logic [6:0] base, input logic [7:0] len, input logic [3:0] ntaps,
                         input bit toggle, input bit poke);
    int idx;
    bit hs;
    idx = 0;
    clear_mon();
    cfg_base = base; cfg_len = len; cfg_ntaps = ntaps;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      s_if.s_valid = (idx < words.size()) && (!toggle || (k % 2 == 0));
      s_if.s_data  = (idx < words.size()) ? words[idx] : 16'h0;
      if (poke) begin
        start = busy;
        cfg_base = 7'd40; cfg_len = 8'd5; cfg_ntaps = 4'd1;
      end
      hs = s_if.s_valid && s_if.s_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      if (!busy) break;
    end
    s_if.s_valid = 1'b0;
    start = 1'b0;
    check_eq("job_terminates", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_ntaps = '0;
    s_if.s_valid = 1'b0; s_if.s_data = '0;
    cyc = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fill: base 0, 4 words, 3 taps.
    words = '{16'h1, 16'h2, 16'h3, 16'h4};
    run_job(7'd0, 8'd4, 4'd3, 1'b0, 1'b0);
    exp_q = '{32'h0000_0001, 32'h0001_0002, 32'h0002_0003, 32'h0003_0004};
    cmp_list("a_wr", wr_log, exp_q);
    exp_q = '{32'd0, 32'd1, 32'd2};
    cmp_list("a_rd", rd_log, exp_q);
    exp_q = '{32'h1, 32'h2, 32'h4};
    cmp_list("a_ld", ld_log, exp_q);
    check_eq("a_clear_pulses", n_clear, 1);
    check_eq("a_done_pulses", n_done, 1);
    check_eq("a_done_latency", done_cyc - clear_cyc, 9);
    check_eq("a_load_after_read", ld_bad, 0);
    check_eq("a_rw_collision", coll, 0);

    // Stalled stream: valid every other cycle.
    words = '{16'h00a1, 16'h00a2, 16'h00a3};
    run_job(7'd10, 8'd3, 4'd1, 1'b1, 1'b0);
    exp_q = '{32'h000a_00a1, 32'h000b_00a2, 32'h000c_00a3};
    cmp_list("b_wr", wr_log, exp_q);
    exp_q = '{32'd10};
    cmp_list("b_rd", rd_log, exp_q);
    exp_q = '{32'h1};
    cmp_list("b_ld", ld_log, exp_q);

    // Address wrap at depth 72.
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_job(7'd70, 8'd4, 4'd2, 1'b0, 1'b0);
    exp_q = '{32'h0046_1111, 32'h0047_2222, 32'h0000_3333, 32'h0001_4444};
    cmp_list("c_wr", wr_log, exp_q);
    exp_q = '{32'd70, 32'd71};
    cmp_list("c_rd", rd_log, exp_q);
    exp_q = '{32'h1, 32'h2};
    cmp_list("c_ld", ld_log, exp_q);
    check_eq("c_done_latency", done_cyc - clear_cyc, 8);

    // Empty job.
    words.delete();
    run_job(7'd5, 8'd0, 4'd0, 1'b0, 1'b0);
    check_eq("d_wr_count", 32'(wr_log.size()), 32'd0);
    check_eq("d_rd_count", 32'(rd_log.size()), 32'd0);
    check_eq("d_ld_count", 32'(ld_log.size()), 32'd0);
    check_eq("d_clear_pulses", n_clear, 1);
    check_eq("d_done_pulses", n_done, 1);
    check_eq("d_done_latency", done_cyc - clear_cyc, 1);

    // Tap clamp, plus start held high while busy (including the done cycle).
    words = '{16'h0005, 16'h0006};
    run_job(7'd20, 8'd2, 4'd9, 1'b0, 1'b1);
    exp_q = '{32'h0014_0005, 32'h0015_0006};
    cmp_list("e_wr", wr_log, exp_q);
    exp_q = '{32'd20, 32'd21, 32'd22};
    cmp_list("e_rd", rd_log, exp_q);
    check_eq("e_ld_or", 32'(ld_or), 32'h7);
    check_eq("e_clear_pulses", n_clear, 1);
    check_eq("e_done_pulses", n_done, 1);

    // Reset mid-fill.
    clear_mon();
    cfg_base = 7'd0; cfg_len = 8'd8; cfg_ntaps = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_if.s_valid = 1'b1; s_if.s_data = 16'hbeef;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    s_if.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    words = '{16'h1, 16'h2, 16'h3, 16'h4};
    run_job(7'd0, 8'd4, 4'd3, 1'b0, 1'b0);
    exp_q = '{32'h0000_0001, 32'h0001_0002, 32'h0002_0003, 32'h0003_0004};
    cmp_list("f_wr", wr_log, exp_q);
    check_eq("f_done_pulses", n_done, 1);

    // Data path option.
    words = '{16'h0200, 16'hfe00};
    run_job(7'd0, 8'd2, 4'd0, 1'b0, 1'b0);
`ifdef WBUFF_FILL_SAT8_EN
    exp_q = '{32'h0000_007f, 32'h0001_ff80};
`else
    exp_q = '{32'h0000_0200, 32'h0001_fe00};
`endif
    cmp_list("g_wr", wr_log, exp_q);
    check_eq("g_ld_count", 32'(ld_log.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
